// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor and its bench.
package pll_sup_pkg;

  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } sup_state_e;

  // Counter width for a count that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_sup_if.sv
// Control/status bundle between the PLL lock supervisor and its surroundings.
interface pll_sup_if;

  // No valid/ready pairs here: enable and pll_locked are levels (pll_locked is
  // asynchronous), retry_req is a self-qualifying one-cycle pulse, and every
  // status output is a registered level that may be sampled on any cycle.
  logic                          enable;
  logic                          pll_locked;
  logic                          retry_req;
  logic                          pll_rst;
  logic                          sys_reset_n;
  logic                          fault;
  logic [pll_sup_pkg::LOSS_W-1:0] lock_loss_cnt;
  logic [2:0]                    state_o;

  modport master (
    input  enable, pll_locked, retry_req,
    output pll_rst, sys_reset_n, fault, lock_loss_cnt, state_o
  );

  modport slave (
    output enable, pll_locked, retry_req,
    input  pll_rst, sys_reset_n, fault, lock_loss_cnt, state_o
  );

endinterface

// File: rtl/bit_sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset to 0.
module bit_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock with bounded retries, and
// gates the downstream reset; lock losses in RUN are counted.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic      refclk,
  input  logic      reset_n,
  pll_sup_if.master sup
);

  localparam int RW = cnt_w(RST_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int NW = cnt_w(MAX_RETRIES + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [NW-1:0] RETRY_MAX = NW'(MAX_RETRIES);

  sup_state_e        state_q, state_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [NW-1:0]     retry_q, retry_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              pll_rst_q, pll_rst_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              fault_q, fault_d;
  logic              locked_s;

  bit_sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (reset_n),
    .d_i    (sup.pll_locked),
    .q_o    (locked_s)
  );

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      timer_q     <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    if (!sup.enable) begin
      state_d   = ST_IDLE;
      rst_cnt_d = '0;
      timer_d   = '0;
      stable_d  = '0;
      retry_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_PLL_RST;
          rst_cnt_d = '0;
        end
        ST_PLL_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = ST_WAIT_LOCK;
            rst_cnt_d = '0;
            timer_d   = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so it beats a same-cycle timeout.
          if (locked_s) begin
            state_d  = ST_STABLE;
            stable_d = '0;
          end else if (timer_q == TMO_LAST) begin
            retry_d   = retry_q + 1'b1;
            timer_d   = '0;
            rst_cnt_d = '0;
            state_d   = (retry_d == RETRY_MAX) ? ST_FAULT : ST_PLL_RST;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d  = ST_WAIT_LOCK;
            timer_d  = '0;
            stable_d = '0;
          end else if (stable_q == STB_LAST) begin
            state_d  = ST_RUN;
            stable_d = '0;
            retry_d  = '0;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d   = ST_PLL_RST;
            rst_cnt_d = '0;
            if (loss_q != LOSS_MAX) loss_d = loss_q + 1'b1;
          end
        end
        ST_FAULT: begin
          if (sup.retry_req) begin
            state_d   = ST_PLL_RST;
            rst_cnt_d = '0;
            retry_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Outputs follow the next state so they change on the same edge as state_o.
    pll_rst_d   = (state_d == ST_IDLE) || (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  assign sup.pll_rst       = pll_rst_q;
  assign sup.sys_reset_n   = sys_rst_n_q;
  assign sup.fault         = fault_q;
  assign sup.lock_loss_cnt = loss_q;
  assign sup.state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: deadline-based reference model with
// per-cycle compare, plus hand-computed latency and status checks.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int R = 4;
  localparam int T = 100;
  localparam int S = 16;
  localparam int M = 2;

  logic refclk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  pll_sup_if bus ();

  pll_lock_supervisor #(
    .RST_CYCLES    (R),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (M)
  ) dut (
    .refclk  (refclk),
    .reset_n (reset_n),
    .sup     (bus)
  );

  // ---------------- clock ----------------
  always #5 refclk = ~refclk;

  // ---------------- reference model ----------------
  // Each timed phase remembers the edge number at which it expires.
  sup_state_e m_st    = ST_IDLE;
  int         m_cyc   = 0;
  int         m_end   = 0;
  int         m_retry = 0;
  int         m_loss  = 0;
  bit         lk_hist[$];

  always @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      m_st    = ST_IDLE;
      m_cyc   = 0;
      m_end   = 0;
      m_retry = 0;
      m_loss  = 0;
      lk_hist = '{1'b0, 1'b0};
    end else begin
      bit lk;
      m_cyc++;
      lk = lk_hist[1];
      lk_hist.push_front(bus.pll_locked);
      void'(lk_hist.pop_back());
      if (!bus.enable) begin
        m_st    = ST_IDLE;
        m_retry = 0;
      end else begin
        case (m_st)
          ST_IDLE: begin m_st = ST_PLL_RST; m_end = m_cyc + R; end
          ST_PLL_RST:
            if (m_cyc == m_end) begin m_st = ST_WAIT_LOCK; m_end = m_cyc + T; end
          ST_WAIT_LOCK:
            if (lk) begin
              m_st = ST_STABLE; m_end = m_cyc + S;
            end else if (m_cyc == m_end) begin
              m_retry++;
              if (m_retry == M) m_st = ST_FAULT;
              else begin m_st = ST_PLL_RST; m_end = m_cyc + R; end
            end
          ST_STABLE:
            if (!lk) begin m_st = ST_WAIT_LOCK; m_end = m_cyc + T; end
            else if (m_cyc == m_end) begin m_st = ST_RUN; m_retry = 0; end
          ST_RUN:
            if (!lk) begin
              m_st   = ST_PLL_RST;
              m_end  = m_cyc + R;
              m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            end
          ST_FAULT:
            if (bus.retry_req) begin m_st = ST_PLL_RST; m_end = m_cyc + R; m_retry = 0; end
          default: m_st = ST_IDLE;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge refclk) begin
    check("cyc_pll_rst", 32'(bus.pll_rst),
          32'((m_st == ST_IDLE) || (m_st == ST_PLL_RST) || (m_st == ST_FAULT)));
    check("cyc_sys_reset_n", 32'(bus.sys_reset_n), 32'(m_st == ST_RUN));
    check("cyc_fault", 32'(bus.fault), 32'(m_st == ST_FAULT));
    check("cyc_loss_cnt", 32'(bus.lock_loss_cnt), 32'(m_loss));
    check("cyc_state", 32'(bus.state_o), 32'(m_st));
  end

  // ---------------- driver tasks ----------------
  // Counts rising edges until the selected output reaches val (0 pll_rst,
  // 1 sys_reset_n, 2 fault); returns limit when it never does.
  task automatic wait_out(input int which, input logic val, input int limit, output int n);
    logic cur;
    n   = 0;
    cur = ~val;
    while (cur !== val && n < limit) begin
      @(posedge refclk);
      #1;
      n++;
      case (which)
        0:       cur = bus.pll_rst;
        1:       cur = bus.sys_reset_n;
        default: cur = bus.fault;
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_rst"}, 32'(bus.pll_rst), 32'd1);
    check({tag, "_sys_reset_n"}, 32'(bus.sys_reset_n), 32'd0);
    check({tag, "_fault"}, 32'(bus.fault), 32'd0);
    check({tag, "_loss_cnt"}, 32'(bus.lock_loss_cnt), 32'd0);
    check({tag, "_state"}, 32'(bus.state_o), 32'(ST_IDLE));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    reset_n        = 1'b0;
    bus.enable     = 1'b0;
    bus.pll_locked = 1'b0;
    bus.retry_req  = 1'b0;
    repeat (3) @(negedge refclk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Nominal lock.
    @(negedge refclk) bus.enable = 1'b1;
    wait_out(0, 1'b0, 50, n);
    check("nom_pll_rst_edges", 32'(n), 32'd5);
    repeat (10) @(negedge refclk);
    bus.pll_locked = 1'b1;
    wait_out(1, 1'b1, 100, n);
    check("nom_lock_to_sys", 32'(n), 32'd19);

    // Glitchy lock: 8 high, 1 low, then steady.
    @(negedge refclk) bus.enable = 1'b0;
    bus.pll_locked = 1'b0;
    @(negedge refclk) bus.enable = 1'b1;
    wait_out(0, 1'b0, 50, n);
    check("glitch_pll_rst_edges", 32'(n), 32'd5);
    @(negedge refclk) bus.pll_locked = 1'b1;
    repeat (8) @(negedge refclk);
    bus.pll_locked = 1'b0;
    @(negedge refclk) bus.pll_locked = 1'b1;
    repeat (2) @(posedge refclk);
    #1;
    check("glitch_back_to_wait", 32'(bus.state_o), 32'(ST_WAIT_LOCK));
    wait_out(1, 1'b1, 100, n);
    check("glitch_relock_to_sys", 32'(n), 32'd17);

    // No lock: two attempts then FAULT.
    @(negedge refclk) bus.enable = 1'b0;
    bus.pll_locked = 1'b0;
    @(negedge refclk) bus.enable = 1'b1;
    wait_out(2, 1'b1, 400, n);
    check("nolock_fault_edges", 32'(n), 32'd209);
    check("nolock_fault_pll_rst", 32'(bus.pll_rst), 32'd1);
    @(negedge refclk) bus.pll_locked = 1'b1;
    repeat (5) @(negedge refclk);
    check("fault_ignores_lock", 32'(bus.fault), 32'd1);
    bus.retry_req = 1'b1;
    @(negedge refclk) bus.retry_req = 1'b0;
    check("retry_clears_fault", 32'(bus.fault), 32'd0);
    check("retry_pll_rst", 32'(bus.pll_rst), 32'd1);
    wait_out(1, 1'b1, 100, n);
    check("retry_relock_to_sys", 32'(n), 32'd21);

    // retry_req outside FAULT is ignored, then three losses in RUN.
    @(negedge refclk) bus.retry_req = 1'b1;
    @(negedge refclk) bus.retry_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge refclk) bus.pll_locked = 1'b0;
      wait_out(1, 1'b0, 4, n);
      check("loss_drop_to_sys", 32'(n), 32'd3);
      @(negedge refclk) bus.pll_locked = 1'b1;
      wait_out(1, 1'b1, 100, n);
      check("loss_relock_to_sys", 32'(n), 32'd21);
    end
    check("loss_cnt_three", 32'(bus.lock_loss_cnt), 32'd3);

    // enable=0 during STABLE.
    @(negedge refclk) bus.enable = 1'b0;
    @(negedge refclk) bus.enable = 1'b1;
    repeat (7) @(posedge refclk);
    #1;
    check("en_in_stable", 32'(bus.state_o), 32'(ST_STABLE));
    @(negedge refclk) bus.enable = 1'b0;
    @(posedge refclk);
    #1;
    check("en_off_idle", 32'(bus.state_o), 32'(ST_IDLE));
    check("en_off_pll_rst", 32'(bus.pll_rst), 32'd1);
    check("en_off_loss_kept", 32'(bus.lock_loss_cnt), 32'd3);
    @(negedge refclk) bus.enable = 1'b1;
    wait_out(1, 1'b1, 100, n);
    check("en_on_to_sys", 32'(n), 32'd22);

    // Asynchronous reset in RUN, then restart from IDLE.
    @(posedge refclk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge refclk) reset_n = 1'b1;
    wait_out(0, 1'b0, 50, n);
    check("post_rst_pll_rst_edges", 32'(n), 32'd5);
    repeat (5) @(negedge refclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
